// File: rtl/io_pkg.sv
// Shared channel-select constants and types for the extracode I/O responder.
package io_pkg;

  typedef logic [3:0] io_sel_t;

  localparam io_sel_t CH_DSKY = 4'd8;
  localparam io_sel_t CH_KEY  = 4'd13;

  // One bit per select value; set bits are the plain output latches (5, 6, 9-12).
  localparam logic [15:0] OUT_CH_MASK = 16'h1E60;

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO with valid/ready on both sides; a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module io_fifo #(
  parameter  int W     = 15,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          rst_l,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  input  logic          out_ready,
  output logic          full,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign full      = (count == CW'(DEPTH));
  assign out_valid = (count != '0);
  assign in_ready  = ~full | out_ready;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // NOTE: storage has no reset; out_data is masked while empty, so stale
  // entries are never visible and the array maps to plain flops/RAM.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_channel_unit.sv
// Channel latches, keyboard input and DSKY output bridge for the extracode
// I/O instructions; read data is returned combinationally to the ALU.
module io_channel_unit
  import io_pkg::*;
#(
  parameter int DATA_W     = 15,
  parameter int FIFO_DEPTH = 4,
  parameter int KEY_W      = 5
) (
  input  logic              clock,
  input  logic              rst_l,
  input  logic              flush,
  input  io_sel_t           io_sel,
  input  logic              io_rd_en,
  input  logic              io_wr_en,
  input  logic [DATA_W-1:0] io_wr_data,
  output logic [DATA_W-1:0] io_rd_data,
  input  logic              key_valid,
  input  logic [KEY_W-1:0]  key_code,
  output logic              key_ready,
  output logic              key_irq,
  output logic              dsky_valid,
  output logic [DATA_W-1:0] dsky_data,
  input  logic              dsky_ready,
  output logic              dsky_ovf
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic              wr;
  logic              rd;
  logic [DATA_W-1:0] chan_q [16];
  logic [DATA_W-1:0] dsky_shadow_q;
  logic [KEY_W-1:0]  key_q;
  logic              key_accept;
  logic              dsky_push;
  logic              fifo_in_ready;
  logic              fifo_full;
  logic [CW-1:0]     fifo_count;

  assign wr         = io_wr_en & ~flush;
  assign rd         = io_rd_en & ~flush;
  assign key_ready  = ~key_irq;
  assign key_accept = key_valid & key_ready;
  assign dsky_push  = wr & (io_sel == CH_DSKY);

  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < 16; i++) chan_q[i] <= '0;
      dsky_shadow_q <= '0;
    end else if (wr) begin
      if (OUT_CH_MASK[io_sel]) chan_q[io_sel] <= io_wr_data;
      if (io_sel == CH_DSKY)   dsky_shadow_q  <= io_wr_data;
    end
  end

  // An accept implies key_irq was low, so it can never race a read-clear.
  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      key_q   <= '0;
      key_irq <= 1'b0;
    end else if (key_accept) begin
      key_q   <= key_code;
      key_irq <= 1'b1;
    end else if (rd && io_sel == CH_KEY) begin
      key_irq <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l)                          dsky_ovf <= 1'b0;
    else if (dsky_push && !fifo_in_ready) dsky_ovf <= 1'b1;
  end

  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    io_rd_data = '0;
    if (OUT_CH_MASK[io_sel])    io_rd_data = chan_q[io_sel];
    else if (io_sel == CH_DSKY) io_rd_data = dsky_shadow_q;
    else if (io_sel == CH_KEY)  io_rd_data = DATA_W'(key_q);
  end

  io_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_dsky_fifo (
    .clock     (clock),
    .rst_l     (rst_l),
    .in_valid  (dsky_push),
    .in_data   (io_wr_data),
    .in_ready  (fifo_in_ready),
    .out_valid (dsky_valid),
    .out_data  (dsky_data),
    .out_ready (dsky_ready),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  a_fifo_flags: assert property (@(posedge clock) disable iff (!rst_l)
    (fifo_full == (fifo_count == CW'(FIFO_DEPTH))) && (dsky_valid == (fifo_count != '0)));

endmodule
